// File: rtl/shift_sequencer_pkg.sv
// Shared types for the multi-cycle shift unit.
// Op encodings and FSM state enum.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master = pipeline side, slave = shift unit.
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [WIDTH-1:0]   data_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [1:0]         op_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [WIDTH-1:0]   res_data_o;

  modport master (
    output req_valid_i,
    output data_i,
    output shamt_i,
    output op_i,
    output res_ready_i,
    input  req_ready_o,
    input  res_valid_o,
    input  res_data_o
  );

  modport slave (
    input  req_valid_i,
    input  data_i,
    input  shamt_i,
    input  op_i,
    input  res_ready_i,
    output req_ready_o,
    output res_valid_o,
    output res_data_o
  );

endinterface

// File: rtl/shift_sequencer_step.sv
// One-bit shift stage; reserved op code falls back to SLL.
// Purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = {din[WIDTH-2:0], 1'b0};
    unique case (1'b1)
      (op == OP_SRL): dout = {1'b0, din[WIDTH-1:1]};
      (op == OP_SRA): dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit beside the EX-stage ALU.
// Applies one 1-bit step per cycle, shamt times.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  shift_sequencer_if.slave   bus,
  output logic               busy_o
);

  state_e             state;
  state_e             next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_step;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op_q;
  logic               accept;

  assign bus.req_ready_o = (state == IDLE) & ~flush_i;
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  assign bus.res_valid_o = (state == DONE);
  assign bus.res_data_o  = acc;
  assign busy_o          = (state != IDLE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (acc),
    .dout (acc_step)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (accept)
          next = (bus.shamt_i == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) next = DONE;
      end
      DONE: begin
        if (bus.res_ready_i) next = IDLE;
      end
      default: next = IDLE;
    endcase
    if (flush_i) next = IDLE;
  end

  // A flush freezes acc/cnt; only the state returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_SLL;
    end else if (accept) begin
      acc  <= bus.data_i;
      cnt  <= bus.shamt_i;
      op_q <= bus.op_i;
    end else if (state == SHIFT && !flush_i) begin
      acc  <= acc_step;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer.
// Directed table, flush/reset sequences, random ops vs reference model.
module tb_shift_sequencer;

  logic clk;
  logic rst_i;
  logic flush_i;
  logic busy_o;

  int checks   = 0;
  int failures = 0;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input logic [4:0]  s,
                                        input logic [1:0]  op);
    case (op)
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  // Called mid-cycle in IDLE; returns mid-cycle in IDLE after handoff.
  task automatic run_txn(input string tag,
                         input logic [31:0] d,
                         input logic [4:0]  s,
                         input logic [1:0]  op,
                         input logic [31:0] exp,
                         input int          stall);
    int cyc;
    bit got;
    bus.req_valid_i = 1'b1;
    bus.data_i      = d;
    bus.shamt_i     = s;
    bus.op_i        = op;
    bus.res_ready_i = (stall == 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.data_i      = $urandom;
    bus.shamt_i     = 5'($urandom);
    bus.op_i        = 2'($urandom);
    cyc = 1;
    got = 0;
    while (cyc <= 40 && !got) begin
      @(negedge clk);
      if (bus.res_valid_o) got = 1;
      else begin
        if (!busy_o) check({tag, " busy"}, 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " done"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(cyc), 32'(s) + 32'd1);
      check({tag, " data"}, bus.res_data_o, exp);
      check({tag, " rdy_in_done"}, 32'(bus.req_ready_o), 32'd0);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " hold_valid"}, 32'(bus.res_valid_o), 32'd1);
        check({tag, " hold_data"}, bus.res_data_o, exp);
        check({tag, " hold_rdy"}, 32'(bus.req_ready_o), 32'd0);
      end
      bus.res_ready_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " post_valid"}, 32'(bus.res_valid_o), 32'd0);
      check({tag, " post_rdy"}, 32'(bus.req_ready_o), 32'd1);
      check({tag, " post_data"}, bus.res_data_o, exp);
    end
  endtask

  vec_t tbl[7];
  logic [31:0] rd;
  logic [4:0]  rs;
  logic [1:0]  ro;

  initial begin
    tbl[0] = '{32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010, 0};
    tbl[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 0};
    tbl[2] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 0};
    tbl[3] = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 3};
    tbl[4] = '{32'hF0F0_F0F0, 5'd8,  2'b10, 32'hFFF0_F0F0, 1};
    tbl[5] = '{32'h1234_5678, 5'd4,  2'b11, 32'h2345_6780, 0};
    tbl[6] = '{32'h8000_0001, 5'd1,  2'b01, 32'h4000_0000, 2};

    rst_i           = 1'b0;
    flush_i         = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.data_i      = '0;
    bus.shamt_i     = '0;
    bus.op_i        = '0;
    bus.res_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst valid", 32'(bus.res_valid_o), 32'd0);
    check("rst data",  bus.res_data_o, 32'd0);
    check("rst busy",  32'(busy_o), 32'd0);
    check("rst ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy_o), 32'd0);

    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i].data, tbl[i].shamt,
              tbl[i].op, tbl[i].exp, tbl[i].stall);

    // Flush in cycle 4 of a shamt=10 SLL; acc holds three steps.
    bus.req_valid_i = 1'b1;
    bus.data_i      = 32'h0000_0003;
    bus.shamt_i     = 5'd10;
    bus.op_i        = 2'b00;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check("flush pre valid", 32'(bus.res_valid_o), 32'd0);
      @(posedge clk); #1;
    end
    flush_i         = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.data_i      = 32'h0000_00A5;
    bus.shamt_i     = 5'd2;
    bus.op_i        = 2'b00;
    @(negedge clk);
    check("flush rdy", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush valid", 32'(bus.res_valid_o), 32'd0);
    check("flush busy",  32'(busy_o), 32'd0);
    check("flush acc",   bus.res_data_o, 32'h0000_0018);
    check("flush ready", 32'(bus.req_ready_o), 32'd1);
    run_txn("after_flush", 32'h0000_00A5, 5'd2, 2'b00,
            32'h0000_0294, 0);

    // Async reset in cycle 3 of a shamt=20 shift.
    bus.req_valid_i = 1'b1;
    bus.data_i      = 32'hFFFF_0000;
    bus.shamt_i     = 5'd20;
    bus.op_i        = 2'b01;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    check("arst valid", 32'(bus.res_valid_o), 32'd0);
    check("arst data",  bus.res_data_o, 32'd0);
    check("arst busy",  32'(busy_o), 32'd0);
    check("arst ready", 32'(bus.req_ready_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    run_txn("after_rst", 32'hFFFF_0000, 5'd20, 2'b01,
            32'h0000_0FFF, 0);

    for (int n = 0; n < 40; n++) begin
      rd = $urandom;
      rs = 5'($urandom);
      ro = 2'($urandom);
      run_txn($sformatf("rnd%0d", n), rd, rs, ro, model(rd, rs, ro),
              int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit. Performs SLL/SRL/SRA on a WIDTH-bit operand by applying a single 1-bit shift stage once per cycle, shamt times.
- Sits beside the EX-stage ALU for shift instructions. A valid/ready request port faces the pipeline and a valid/ready result port returns the value.
- Exposes busy_o to the hazard unit so it can stall younger instructions.
- flush_i aborts the operation on a branch or exception flush.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous abort of the in-flight operation.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  unit can accept a request.
- data_i  input  WIDTH  operand.
- shamt_i  input  SHAMT_W  shift amount, 0..WIDTH-1.
- op_i  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (executes as SLL).
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  consumer takes the result.
- res_data_o  output  WIDTH  shifted result.
- busy_o  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, acc=0, cnt=0, op register=SLL.
  - Outputs during reset: res_valid_o=0, res_data_o=0, busy_o=0, req_ready_o=1 (provided flush_i=0).
- States: IDLE, SHIFT, DONE.
- req_ready_o = (state==IDLE) & ~flush_i, combinational. A request is accepted only in IDLE.
- IDLE, on req_valid_i & req_ready_o:
  - acc<=data_i, cnt<=shamt_i, op register<=op_i.
  - Next state is DONE if shamt_i==0, else SHIFT.
- SHIFT, each cycle:
  - acc<=step(acc, op), cnt<=cnt-1.
  - When cnt==1, next state is DONE.
- step function:
  - SLL: {acc[WIDTH-2:0],1'b0}.
  - SRL: {1'b0,acc[WIDTH-1:1]}.
  - SRA: {acc[WIDTH-1],acc[WIDTH-1:1]}.
- DONE:
  - res_valid_o=1.
  - On res_ready_i, next state is IDLE.
  - No request is accepted in the same cycle as the result handoff; the earliest back-to-back acceptance is the cycle after handoff.
- Latency: a request accepted in cycle 0 raises res_valid_o in cycle shamt+1 (shamt=0 gives cycle 1; shamt=31 gives cycle 32).
- res_data_o = acc at all times. It is held stable while res_valid_o=1 and is not cleared on handoff.
- Backpressure: DONE holds indefinitely while res_ready_i=0. acc and res_valid_o are unchanged.
- flush_i has the highest synchronous priority:
  - From any state, next state is IDLE and the result is discarded (res_valid_o low next cycle).
  - acc and cnt keep their current values.
  - A request presented in a flush cycle is not accepted.
  - A flush in DONE with res_ready_i=1 in the same cycle: the handoff still counts; the consumer owns the flush decision.
- Reset mid-operation: immediate return to reset values; no pending result survives.
- Inputs data_i, shamt_i and op_i are sampled only at acceptance. Later changes have no effect.
- cnt never underflows; SHIFT is entered only with cnt>=1.

Decomposition:
- Shared package, shift_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10.
  - state enum IDLE/SHIFT/DONE.
- Sub-module shift_step: combinational one-bit shift stage (WIDTH, op, in, out), instantiated once in the loop.

Test Plan:
- Reset: rst_i=0 with clock running -> res_valid_o=0, res_data_o=0, busy_o=0, req_ready_o=1. Release rst_i -> state IDLE.
- SLL: data_i=32'h0000_0001, shamt_i=4, op=00, res_ready_i=1 -> res_valid_o rises exactly 5 cycles after acceptance, res_data_o=32'h0000_0010, busy_o high in the 5 cycles between.
- SRA/SRL: data_i=32'h8000_0000, shamt_i=31.
  - op=10 -> 32'hFFFF_FFFF after 32 cycles.
  - op=01 -> 32'h0000_0001.
- shamt_i=0 with data_i=32'hDEAD_BEEF -> res_valid_o in cycle 1 with 32'hDEAD_BEEF. res_ready_i held 0 for 3 cycles -> output stable, req_ready_o=0 throughout.
- Flush: accept shamt_i=10, assert flush_i in cycle 4 -> IDLE next cycle, res_valid_o never asserts. A request with flush_i=1 is not accepted; the same request on the following cycle completes normally.
- Async reset asserted in cycle 3 of a shamt=20 shift -> outputs go to reset values without waiting for a clock edge. A new request after release returns the correct result.
